axi_latency_monitor: RTL
========================

Name: axi_latency_monitor

Overview:
Per-transaction latency monitor for one AXI master channel pair (AR→R-last or AW→B) of the perf-test kernel. It consumes the qualified handshake strobes and IDs that the kernel top derives from the host-memory AXI master (tt_arvalid/tt_arid with tt_rlast/tt_rid, or tt_awvalid/tt_awid with tt_bvalid/tt_bid). It produces accumulated latency statistics for the AXI-Lite register hub. It is instantiated twice, once for reads and once for writes.

Parameters:
ID_WIDTH, 5, width of the AXI transaction ID; the ID table has 2**ID_WIDTH entries
TS_WIDTH, 32, width of the free-running timestamp and of per-transaction latency
SUM_WIDTH, 64, width of the latency accumulator

Ports:
clk  in  1  kernel clock
rst  in  1  synchronous, active-high reset
clear  in  1  single-cycle pulse (engine_start_pulse); clears stats and the table
req_valid  in  1  request accepted this cycle (addr valid & ready)
req_id  in  ID_WIDTH  ID of the accepted request
cpl_valid  in  1  transaction completed this cycle (rlast & rvalid & rready, or bvalid & bready)
cpl_id  in  ID_WIDTH  ID of the completion
cpl_count  out  32  number of completed transactions measured
lat_total  out  SUM_WIDTH  sum of all measured latencies
lat_min  out  TS_WIDTH  smallest latency measured
lat_max  out  TS_WIDTH  largest latency measured
outstanding  out  ID_WIDTH+1  number of valid table entries
err_orphan  out  1  sticky: a completion arrived for an ID with no open entry
err_reuse  out  1  sticky: a request arrived for an ID that is already open

Behaviour:
- Decided: one clock (clk); reset rst is synchronous and active-high.
- Reset values: cpl_count=0, lat_total=0, lat_min=all ones, lat_max=0, outstanding=0, err_*=0, timestamp=0, all table valid bits=0, pipeline valid=0.
- Timestamp: TS_WIDTH free-running counter, +1 every cycle, wraps silently.
- Table: per ID, one valid bit and one stored timestamp (TS_WIDTH).
- req_valid on a closed entry: store the current timestamp and set valid.
- req_valid on an open entry (no same-cycle completion for that ID): set err_reuse. Overwrite the timestamp with the newest request; valid stays 1.
- cpl_valid on an open entry: read the stored timestamp and clear valid, then enter the latency pipeline.
- cpl_valid on a closed entry: set err_orphan; no statistics update.
- Same cycle, req_id==cpl_id, entry open: the completion uses the OLD timestamp. The new request stores the current timestamp. valid stays 1; no error.
- Same cycle, req_id==cpl_id, entry closed: set err_orphan. The request is stored normally.
- Same cycle, different IDs: handle both independently.
- outstanding: +1 on a new open and -1 on a close. Both in one cycle leave it unchanged. It never over- or underflows, because each event is gated by the valid bit.
- Pipeline stage 1 (cycle after cpl): lat = ts_now_at_cpl - stored_ts, modulo 2**TS_WIDTH (wrap-safe). A request and completion on consecutive cycles give lat=1.
- Pipeline stage 2 (following cycle): update the outputs.
  - cpl_count +=1, saturating at 0xFFFFFFFF.
  - lat_total +=lat, saturating at all ones.
  - lat_min = min(lat_min, lat); lat_max = max(lat_max, lat).
- Output latency: the statistics reflect a completion exactly 2 cycles after cpl_valid. The outputs are registered. At most one completion per cycle, so the pipeline never stalls.
- clear: same effect as rst on all state except the timestamp, which keeps counting. Pipeline stages in flight on the clear cycle are discarded. A req/cpl in the clear cycle is ignored.
- rst mid-operation: all open entries are dropped. A completion arriving after reset is flagged err_orphan.

Decomposition:
- Shared package perf_mon_pkg:
  - ID_WIDTH_DEF, TS_WIDTH_DEF and SUM_WIDTH_DEF constants.
  - lat_stats_t struct (count, total, min, max) used by the register hub.
- Natural sub-module: lat_id_table, holding the valid bits, the timestamp RAM, and the same-ID bypass and error logic.
- The statistics accumulator stays in the top.

Test Plan:
- Single: req id=3 at t=10, cpl id=3 at t=25 → at t=27: cpl_count=1, lat_total=15, lat_min=15, lat_max=15, outstanding=0.
- Interleaved: req id 0,1,2 at t=0,1,2; cpl 2,0,1 at t=5,9,12 → lat_total=3+9+11=23, lat_min=3, lat_max=11, cpl_count=3.
- Same-cycle: req id=4 at t=0; at t=7, cpl id=4 plus req id=4; cpl id=4 at t=10 → latencies 7 and 3, no error, outstanding 0 at the end.
- Errors: cpl id=9 with nothing open → err_orphan=1 and count unchanged; two reqs id=1 without cpl → err_reuse=1, outstanding=1.
- Wrap: force the timestamp to 0xFFFFFFFE, req id=0, cpl 4 cycles later → lat=4.
- Clear/reset: open 5 IDs, pulse clear → outstanding=0, lat_min=0xFFFFFFFF; a later cpl on one of those IDs sets err_orphan.

Source files
------------

// File: rtl/perf_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_mon_pkg
// Purpose  : Shared constants, types and helpers for the perf-test kernel
//            latency monitors and the AXI-Lite register hub that reads them.
// Contents : ID_WIDTH_DEF / TS_WIDTH_DEF / SUM_WIDTH_DEF default widths,
//            CNT_WIDTH completion-counter width, lat_stats_t statistics
//            record, cnt_sat_inc saturating counter increment.
// Revision : 1.0 - initial release
// ============================================================================
package perf_mon_pkg;

  localparam int ID_WIDTH_DEF  = 5;
  localparam int TS_WIDTH_DEF  = 32;
  localparam int SUM_WIDTH_DEF = 64;
  localparam int CNT_WIDTH     = 32;

  // Snapshot of one monitor's statistics as the register hub sees them.
  typedef struct packed {
    logic [CNT_WIDTH-1:0]     count;
    logic [SUM_WIDTH_DEF-1:0] total;
    logic [TS_WIDTH_DEF-1:0]  lat_min;
    logic [TS_WIDTH_DEF-1:0]  lat_max;
  } lat_stats_t;

  // Increment that sticks at all ones instead of wrapping to zero.
  function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] value);
    logic [CNT_WIDTH-1:0] w_one;
    w_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return (&value) ? value : value + w_one;
  endfunction

endpackage : perf_mon_pkg
`default_nettype wire

// File: rtl/lat_id_table.sv
`default_nettype none
// ============================================================================
// Module   : lat_id_table
// Purpose  : Per-ID open-transaction table for the latency monitor. Holds a
//            valid bit and the request timestamp for each AXI ID, resolves
//            same-cycle request/completion on one ID, counts open entries
//            and raises the sticky orphan / reuse error flags.
// Ports    : clk, rst, clear      - clock, sync reset, stats/table clear
//            req_valid, req_id    - accepted request strobe and its ID
//            cpl_valid, cpl_id    - completion strobe and its ID
//            ts_now               - current free-running timestamp
//            cpl_hit              - completion matched an open entry
//            cpl_ts               - timestamp stored for cpl_id
//            outstanding          - number of open entries
//            err_orphan/err_reuse - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module lat_id_table
  import perf_mon_pkg::*;
#(
  parameter int ID_WIDTH = ID_WIDTH_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                req_valid,
  input  logic [ID_WIDTH-1:0] req_id,
  input  logic                cpl_valid,
  input  logic [ID_WIDTH-1:0] cpl_id,
  input  logic [TS_WIDTH-1:0] ts_now,
  output logic                cpl_hit,
  output logic [TS_WIDTH-1:0] cpl_ts,
  output logic [ID_WIDTH:0]   outstanding,
  output logic                err_orphan,
  output logic                err_reuse
);

  localparam int            c_depth = 2 ** ID_WIDTH;
  localparam logic [ID_WIDTH:0] c_one = {{ID_WIDTH{1'b0}}, 1'b1};

  logic [c_depth-1:0]  r_valid;
  logic [TS_WIDTH-1:0] r_ts_mem [c_depth];
  logic [ID_WIDTH:0]   r_outstanding;
  logic                r_err_orphan;
  logic                r_err_reuse;

  logic w_req_open;
  logic w_cpl_open;
  logic w_same_id;
  logic w_cpl_hit;
  logic w_cpl_orphan;
  logic w_req_reuse;
  logic w_req_new;

  always_comb begin
    w_req_open   = r_valid[req_id];
    w_cpl_open   = r_valid[cpl_id];
    w_same_id    = req_valid & cpl_valid & (req_id == cpl_id);
    w_cpl_hit    = cpl_valid & w_cpl_open;
    w_cpl_orphan = cpl_valid & ~w_cpl_open;
    // A request landing on the entry its own-cycle completion is closing is
    // a legal back-to-back reuse, not an error.
    w_req_reuse  = req_valid & w_req_open & ~w_same_id;
    // The request counts as a fresh open when the entry is closed, or when
    // the same-cycle completion closes it first; the latter cancels the
    // completion's decrement so outstanding stays put.
    w_req_new    = req_valid & (~w_req_open | w_same_id);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_valid       <= '0;
      r_outstanding <= '0;
      r_err_orphan  <= 1'b0;
      r_err_reuse   <= 1'b0;
    end else begin
      // Completion clears first so a same-ID request re-sets the bit.
      if (w_cpl_hit) begin
        r_valid[cpl_id] <= 1'b0;
      end
      if (req_valid) begin
        r_valid[req_id] <= 1'b1;
      end

      case ({w_req_new, w_cpl_hit})
        2'b10:   r_outstanding <= r_outstanding + c_one;
        2'b01:   r_outstanding <= r_outstanding - c_one;
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_cpl_orphan) begin
        r_err_orphan <= 1'b1;
      end
      if (w_req_reuse) begin
        r_err_reuse <= 1'b1;
      end
    end
  end

  // Timestamp RAM needs no reset: entries are only read behind a valid bit.
  // A reused ID simply takes the newest request's timestamp.
  always_ff @(posedge clk) begin
    if (!rst && !clear && req_valid) begin
      r_ts_mem[req_id] <= ts_now;
    end
  end

  // Read of the old timestamp happens before the same-cycle write lands.
  assign cpl_hit     = w_cpl_hit;
  assign cpl_ts      = r_ts_mem[cpl_id];
  assign outstanding = r_outstanding;
  assign err_orphan  = r_err_orphan;
  assign err_reuse   = r_err_reuse;

endmodule : lat_id_table
`default_nettype wire

// File: rtl/axi_latency_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axi_latency_monitor
// Purpose  : Per-transaction latency monitor for one AXI request/completion
//            channel pair (AR->R-last or AW->B). Timestamps each accepted
//            request by ID, measures the latency at completion and keeps
//            count / total / min / max statistics for the register hub.
// Ports    : clk, rst            - kernel clock, sync active-high reset
//            clear               - engine start pulse, clears stats + table
//            req_valid, req_id   - accepted request strobe and ID
//            cpl_valid, cpl_id   - completion strobe and ID
//            cpl_count           - completions measured (saturating)
//            lat_total           - latency sum (saturating)
//            lat_min, lat_max    - extreme latencies seen
//            outstanding         - open table entries
//            err_orphan          - sticky: completion without open entry
//            err_reuse           - sticky: request on an already open ID
// Revision : 1.0 - initial release
// ============================================================================
module axi_latency_monitor
  import perf_mon_pkg::*;
#(
  parameter int ID_WIDTH  = ID_WIDTH_DEF,
  parameter int TS_WIDTH  = TS_WIDTH_DEF,
  parameter int SUM_WIDTH = SUM_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 req_valid,
  input  logic [ID_WIDTH-1:0]  req_id,
  input  logic                 cpl_valid,
  input  logic [ID_WIDTH-1:0]  cpl_id,
  output logic [31:0]          cpl_count,
  output logic [SUM_WIDTH-1:0] lat_total,
  output logic [TS_WIDTH-1:0]  lat_min,
  output logic [TS_WIDTH-1:0]  lat_max,
  output logic [ID_WIDTH:0]    outstanding,
  output logic                 err_orphan,
  output logic                 err_reuse
);

  localparam logic [TS_WIDTH-1:0] c_ts_one = {{(TS_WIDTH-1){1'b0}}, 1'b1};
  localparam int                  c_pad    = SUM_WIDTH + 1 - TS_WIDTH;

  // Free-running timestamp; clear deliberately leaves it running.
  logic [TS_WIDTH-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + c_ts_one;
    end
  end

  logic                w_cpl_hit;
  logic [TS_WIDTH-1:0] w_cpl_ts;

  lat_id_table #(
    .ID_WIDTH (ID_WIDTH),
    .TS_WIDTH (TS_WIDTH)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .cpl_valid   (cpl_valid),
    .cpl_id      (cpl_id),
    .ts_now      (r_ts),
    .cpl_hit     (w_cpl_hit),
    .cpl_ts      (w_cpl_ts),
    .outstanding (outstanding),
    .err_orphan  (err_orphan),
    .err_reuse   (err_reuse)
  );

  // Stage 1: latency of the completion seen last cycle. Modulo subtraction
  // keeps it correct across a timestamp wrap.
  logic                r_s1_valid;
  logic [TS_WIDTH-1:0] r_s1_lat;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_s1_valid <= 1'b0;
      r_s1_lat   <= '0;
    end else begin
      r_s1_valid <= w_cpl_hit;
      r_s1_lat   <= r_ts - w_cpl_ts;
    end
  end

  // Stage 2: fold the latency into the statistics.
  logic [31:0]          r_cpl_count;
  logic [SUM_WIDTH-1:0] r_lat_total;
  logic [TS_WIDTH-1:0]  r_lat_min;
  logic [TS_WIDTH-1:0]  r_lat_max;
  logic [SUM_WIDTH:0]   w_sum_ext;

  // One extra bit catches the carry that triggers saturation.
  assign w_sum_ext = {1'b0, r_lat_total} + {{c_pad{1'b0}}, r_s1_lat};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cpl_count <= '0;
      r_lat_total <= '0;
      r_lat_min   <= '1;
      r_lat_max   <= '0;
    end else if (r_s1_valid) begin
      r_cpl_count <= cnt_sat_inc(r_cpl_count);
      r_lat_total <= w_sum_ext[SUM_WIDTH] ? '1 : w_sum_ext[SUM_WIDTH-1:0];
      if (r_s1_lat < r_lat_min) begin
        r_lat_min <= r_s1_lat;
      end
      if (r_s1_lat > r_lat_max) begin
        r_lat_max <= r_s1_lat;
      end
    end
  end

  assign cpl_count = r_cpl_count;
  assign lat_total = r_lat_total;
  assign lat_min   = r_lat_min;
  assign lat_max   = r_lat_max;

endmodule : axi_latency_monitor
`default_nettype wire
